// File: rtl/sdram_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// sdram_port_arbiter
//   Shares the sdram_controller host port between display reads and pixel
//   writes; reads win arbitration, with a burst cap so writes cannot starve.
// Revision: 1.0 - initial release
// ============================================================================
module sdram_port_arbiter #(
   parameter int ADDR_W         = 24,
   parameter int DATA_W         = 16,
   parameter int MAX_READ_BURST = 8,
   parameter int ACCEPT_TIMEOUT = 15
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_ack,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   output logic [ADDR_W-1:0] sd_addr,
   output logic [DATA_W-1:0] sd_wr_data,
   output logic              sd_wr_enable,
   output logic              sd_rd_enable,
   input  logic [DATA_W-1:0] sd_rd_data,
   input  logic              sd_rd_ready,
   input  logic              sd_busy,
   output logic              timeout_err,
   output logic [3:0]        read_starve_cnt
);

   localparam int         TMR_W      = $clog2(ACCEPT_TIMEOUT + 1);
   localparam logic [3:0] STARVE_CAP = 4'(MAX_READ_BURST);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RD_ISSUE  = 3'd1,
      RD_WAIT   = 3'd2,
      WR_ISSUE  = 3'd3,
      WR_ACCEPT = 3'd4,
      WR_WAIT   = 3'd5
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [TMR_W-1:0] timer;
   logic             timer_expired;
   logic             grant_rd;
   logic             grant_wr;
   logic             rd_done;
   logic             wr_done;
   logic             timeout_hit;

   assign sd_rd_enable  = (state == RD_ISSUE);
   assign sd_wr_enable  = (state == WR_ISSUE);
   assign timer_expired = (timer == TMR_W'(ACCEPT_TIMEOUT - 1));

   always_comb begin
      state_nxt   = state;
      grant_rd    = 1'b0;
      grant_wr    = 1'b0;
      rd_done     = 1'b0;
      wr_done     = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            // The ack cycle is skipped so a still-held request is not granted twice.
            if (!sd_busy && !rd_ack && !wr_ack) begin
               if (rd_req && (!wr_req || read_starve_cnt < STARVE_CAP)) begin
                  grant_rd  = 1'b1;
                  state_nxt = RD_ISSUE;
               end else if (wr_req) begin
                  grant_wr  = 1'b1;
                  state_nxt = WR_ISSUE;
               end
            end
         end
         RD_ISSUE: state_nxt = RD_WAIT;
         RD_WAIT: begin
            if (sd_rd_ready) begin
               rd_done   = 1'b1;
               state_nxt = IDLE;
            end else if (!sd_busy && timer_expired) begin
               timeout_hit = 1'b1;
               state_nxt   = IDLE;
            end
         end
         WR_ISSUE: state_nxt = WR_ACCEPT;
         WR_ACCEPT: begin
            if (sd_busy) begin
               state_nxt = WR_WAIT;
            end else if (timer_expired) begin
               timeout_hit = 1'b1;
               state_nxt   = IDLE;
            end
         end
         WR_WAIT: begin
            if (!sd_busy) begin
               wr_done   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         timer           <= '0;
         rd_ack          <= 1'b0;
         wr_ack          <= 1'b0;
         rd_data         <= '0;
         sd_addr         <= '0;
         sd_wr_data      <= '0;
         timeout_err     <= 1'b0;
         read_starve_cnt <= '0;
      end else begin
         rd_ack <= rd_done;
         wr_ack <= wr_done;
         if (rd_done) begin
            rd_data <= sd_rd_data;
         end
         if (grant_rd) begin
            sd_addr <= rd_addr;
         end
         if (grant_wr) begin
            sd_addr    <= wr_addr;
            sd_wr_data <= wr_data;
         end
         if (timeout_hit) begin
            timeout_err <= 1'b1;
         end
         // Timer freezes in RD_WAIT while the controller reports busy.
         if (state == RD_ISSUE || state == WR_ISSUE) begin
            timer <= '0;
         end else if ((state == RD_WAIT && !sd_busy) || state == WR_ACCEPT) begin
            timer <= timer + 1'b1;
         end
         if (grant_wr || (state == IDLE && !wr_req)) begin
            read_starve_cnt <= '0;
         end else if (grant_rd && wr_req) begin
            read_starve_cnt <= read_starve_cnt + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_sdram_port_arbiter
//   Directed and randomized checks of sdram_port_arbiter against a behavioural
//   controller/requester model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sdram_port_arbiter;

   localparam int ADDR_W = 24;
   localparam int DATA_W = 16;
   localparam int MAXB   = 8;
   localparam int TMO    = 15;

   logic              clock = 1'b0;
   logic              reset;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_ack;
   logic [DATA_W-1:0] rd_data;
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ack;
   logic [ADDR_W-1:0] sd_addr;
   logic [DATA_W-1:0] sd_wr_data;
   logic              sd_wr_enable;
   logic              sd_rd_enable;
   logic [DATA_W-1:0] sd_rd_data;
   logic              sd_rd_ready;
   logic              sd_busy;
   logic              timeout_err;
   logic [3:0]        read_starve_cnt;

   always #5 clock = ~clock;

   sdram_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_READ_BURST(MAXB), .ACCEPT_TIMEOUT(TMO)
   ) dut (
      .clock(clock), .reset(reset),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
      .sd_addr(sd_addr), .sd_wr_data(sd_wr_data), .sd_wr_enable(sd_wr_enable),
      .sd_rd_enable(sd_rd_enable), .sd_rd_data(sd_rd_data), .sd_rd_ready(sd_rd_ready),
      .sd_busy(sd_busy), .timeout_err(timeout_err), .read_starve_cnt(read_starve_cnt)
   );

   int checks   = 0;
   int failures = 0;

   // controller model state
   bit          auto_ctrl = 1'b0;
   int          rd_cnt, wr_dly, busy_left;
   logic [23:0] rd_lat_addr;

   int n, ens, acks, nreads, nwrites, cyc, rw_cnt, rd_age, wr_age, max_age, n_rd_ack, n_wr_ack;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] mem_fn(input logic [23:0] a);
      return a[15:0] ^ {a[23:16], 8'hA5};
   endfunction

   function automatic logic sel(input int w);
      case (w)
         0:       return sd_rd_enable;
         1:       return sd_wr_enable;
         2:       return rd_ack;
         3:       return wr_ack;
         default: return timeout_err;
      endcase
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Behavioural controller: read data after 1..5 cycles, write busy after
   // 1..3 cycles lasting 1..6 cycles.
   task automatic ctrl_tick();
      if (!auto_ctrl) return;
      sd_rd_ready = 1'b0;
      if (rd_cnt > 0) begin
         rd_cnt--;
         if (rd_cnt == 0) begin
            sd_rd_ready = 1'b1;
            sd_rd_data  = mem_fn(rd_lat_addr);
         end
      end
      if (sd_rd_enable) begin
         rd_cnt      = int'($urandom_range(1, 5));
         rd_lat_addr = sd_addr;
      end
      if (wr_dly > 0) begin
         wr_dly--;
         if (wr_dly == 0) busy_left = int'($urandom_range(1, 6));
      end
      sd_busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      if (sd_wr_enable) wr_dly = int'($urandom_range(1, 3));
   endtask

   task automatic wait_for(input int which, input int bound, input string tag, output int cnt);
      cnt = 0;
      while (!sel(which) && cnt < bound) begin
         step();
         ctrl_tick();
         cnt++;
      end
      check(tag, 32'(sel(which)), 1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      auto_ctrl = 1'b0;
      rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
      sd_busy = 1'b0; sd_rd_ready = 1'b0; sd_rd_data = '0;
      rd_cnt = 0; wr_dly = 0; busy_left = 0;
      repeat (2) step();
      check("reset_rd_data", 32'(rd_data), 0);
      check("reset_sd_addr", 32'(sd_addr), 0);
      check("reset_sd_wr_data", 32'(sd_wr_data), 0);
      check("reset_ctl", 32'({sd_rd_enable, sd_wr_enable, rd_ack, wr_ack, timeout_err, read_starve_cnt}), 0);
      reset = 1'b0;
      step();
   endtask

   initial begin
      reset = 1'b1;

      // Uncontended read, controller answers 5 cycles after the enable
      do_reset();
      rd_req = 1'b1; rd_addr = 24'h012345;
      wait_for(0, 10, "t1_rd_en", n);
      check("t1_sd_addr", 32'(sd_addr), 32'h012345);
      ens = 0; acks = 0;
      for (int i = 1; i <= 5; i++) begin
         step();
         ens += int'(sd_rd_enable); acks += int'(rd_ack);
         if (i == 5) begin sd_rd_ready = 1'b1; sd_rd_data = 16'hBEEF; end
      end
      check("t1_single_en_no_early_ack", ens + acks, 0);
      step();
      sd_rd_ready = 1'b0; sd_rd_data = '0;
      check("t1_rd_ack", 32'(rd_ack), 1);
      check("t1_rd_data", 32'(rd_data), 32'hBEEF);
      rd_req = 1'b0;
      step();
      check("t1_ack_one_cycle", 32'({rd_ack, sd_rd_enable}), 0);
      check("t1_rd_data_held", 32'(rd_data), 32'hBEEF);

      // Uncontended write, controller busy for 6 cycles
      wr_req = 1'b1; wr_addr = 24'h000100; wr_data = 16'h801F;
      wait_for(1, 10, "t2_wr_en", n);
      check("t2_sd_addr", 32'(sd_addr), 32'h000100);
      check("t2_sd_wr_data", 32'(sd_wr_data), 32'h801F);
      ens = 0; acks = 0;
      for (int i = 1; i <= 7; i++) begin
         step();
         ens += int'(sd_wr_enable); acks += int'(wr_ack) + int'(rd_ack);
         sd_busy = (i <= 6);
      end
      check("t2_single_en_no_early_ack", ens + acks, 0);
      step();
      check("t2_wr_ack", 32'(wr_ack), 1);
      wr_req = 1'b0;
      step();
      check("t2_ack_one_cycle", 32'(wr_ack), 0);

      // Starvation cap with both requests held continuously
      do_reset();
      auto_ctrl = 1'b1;
      rd_req = 1'b1; rd_addr = 24'($urandom);
      wr_req = 1'b1; wr_addr = 24'($urandom); wr_data = 16'($urandom);
      nreads = 0; nwrites = 0; cyc = 0;
      while (nwrites < 3 && cyc < 800) begin
         step();
         if (sd_rd_enable) begin
            nreads++;
            check("t3_rd_addr", 32'(sd_addr), 32'(rd_addr));
         end
         if (sd_wr_enable) begin
            check("t3_reads_before_write", nreads, MAXB);
            check("t3_starve_cleared", 32'(read_starve_cnt), 0);
            check("t3_wr_addr", 32'(sd_addr), 32'(wr_addr));
            nreads = 0; nwrites++;
         end
         if (rd_ack) begin
            check("t3_rd_data", 32'(rd_data), 32'(mem_fn(rd_addr)));
            rd_addr = 24'($urandom);
         end
         if (wr_ack) begin
            wr_addr = 24'($urandom); wr_data = 16'($urandom);
         end
         ctrl_tick();
         cyc++;
      end
      check("t3_write_grants", nwrites, 3);

      // Busy gating: no grant while sd_busy, read wins after release
      do_reset();
      sd_busy = 1'b1; rd_req = 1'b1; wr_req = 1'b1;
      rd_addr = 24'h0A0B0C; wr_addr = 24'h0D0E0F; wr_data = 16'h5555;
      ens = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         ens += int'(sd_rd_enable) + int'(sd_wr_enable);
      end
      check("t4_no_grant_while_busy", ens, 0);
      sd_busy = 1'b0;
      n = 0;
      while (!sd_rd_enable && !sd_wr_enable && n < 6) begin step(); n++; end
      check("t4_first_grant_read", 32'({sd_rd_enable, sd_wr_enable}), 32'b10);
      check("t4_read_addr", 32'(sd_addr), 32'h0A0B0C);

      // Accept timeout: sd_busy never rises after the write enable
      do_reset();
      wr_req = 1'b1; wr_addr = 24'h0055AA; wr_data = 16'h1234;
      wait_for(1, 10, "t5_wr_en", n);
      n = 0; acks = 0;
      while (!timeout_err && n < 40) begin
         step(); n++; acks += int'(wr_ack);
      end
      check("t5_timeout_set", 32'(timeout_err), 1);
      check("t5_timeout_after_15", 32'(n >= TMO && n <= TMO + 1), 1);
      check("t5_no_ack_on_timeout", acks, 0);
      wait_for(1, 6, "t5_reissue", n);
      check("t5_reissue_addr", 32'(sd_addr), 32'h0055AA);
      auto_ctrl = 1'b1;
      ctrl_tick();
      wait_for(3, 30, "t5_wr_ack_after_retry", n);
      wr_req = 1'b0;
      step();
      check("t5_timeout_sticky", 32'(timeout_err), 1);

      // Async reset while in RD_WAIT
      do_reset();
      rd_req = 1'b1; rd_addr = 24'h3C0F00;
      wait_for(0, 10, "t6_rd_en", n);
      step();
      #2 reset = 1'b1;
      #1;
      check("t6_async_sd_addr", 32'(sd_addr), 0);
      check("t6_async_ctl", 32'({sd_rd_enable, sd_wr_enable, rd_ack, wr_ack, timeout_err, read_starve_cnt}), 0);
      sd_rd_ready = 1'b1; sd_rd_data = 16'hCAFE;
      acks = 0;
      repeat (2) begin step(); acks += int'(rd_ack); end
      sd_rd_ready = 1'b0; sd_rd_data = '0;
      reset = 1'b0;
      step(); acks += int'(rd_ack);
      check("t6_no_ack_after_reset", acks, 0);
      check("t6_rd_data_cleared", 32'(rd_data), 0);
      wait_for(0, 10, "t6_reissue", n);
      check("t6_reissue_addr", 32'(sd_addr), 32'h3C0F00);
      auto_ctrl = 1'b1;
      ctrl_tick();
      wait_for(2, 20, "t6_rd_ack", n);
      check("t6_rd_data", 32'(rd_data), 32'(mem_fn(24'h3C0F00)));
      rd_req = 1'b0;

      // Randomized traffic against the scoreboard
      do_reset();
      auto_ctrl = 1'b1;
      rw_cnt = 0; rd_age = 0; wr_age = 0; max_age = 0; n_rd_ack = 0; n_wr_ack = 0;
      for (int c = 0; c < 3000; c++) begin
         step();
         if (!wr_req) rw_cnt = 0;
         if (sd_rd_enable) begin
            check("t7_rd_grant_valid", 32'({rd_req, sd_wr_enable}), 32'b10);
            check("t7_rd_addr", 32'(sd_addr), 32'(rd_addr));
            if (wr_req) begin
               rw_cnt++;
               check("t7_read_burst_cap", 32'(rw_cnt <= MAXB), 1);
            end
         end
         if (sd_wr_enable) begin
            check("t7_wr_grant_valid", 32'(wr_req), 1);
            check("t7_wr_addr", 32'(sd_addr), 32'(wr_addr));
            check("t7_wr_data", 32'(sd_wr_data), 32'(wr_data));
            rw_cnt = 0;
         end
         if (rd_req) rd_age++;
         if (wr_req) wr_age++;
         if (rd_age > max_age) max_age = rd_age;
         if (wr_age > max_age) max_age = wr_age;
         if (rd_ack) begin
            check("t7_rd_ack_valid", 32'({rd_req, wr_ack}), 32'b10);
            check("t7_rd_data", 32'(rd_data), 32'(mem_fn(rd_addr)));
            rd_req = 1'b0; rd_age = 0; n_rd_ack++;
         end else if (!rd_req && $urandom_range(0, 3) == 0) begin
            rd_req = 1'b1; rd_addr = 24'($urandom);
         end
         if (wr_ack) begin
            check("t7_wr_ack_valid", 32'(wr_req), 1);
            wr_req = 1'b0; wr_age = 0; n_wr_ack++;
         end else if (!wr_req && $urandom_range(0, 2) == 0) begin
            wr_req = 1'b1; wr_addr = 24'($urandom); wr_data = 16'($urandom);
         end
         ctrl_tick();
      end
      check("t7_no_request_starved", 32'(max_age <= 200), 1);
      check("t7_reads_completed", 32'(n_rd_ack > 50), 1);
      check("t7_writes_completed", 32'(n_wr_ack > 50), 1);
      check("t7_no_timeout", 32'(timeout_err), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single host port of sdram_controller between two requesters: the display refill path (reads) and the game pixel writer (writes).
- Sequences each access as an enable pulse, then a wait for controller completion. Display reads take priority; a burst cap stops writes from starving.
- Runs in the CLOCK_200 domain, between the FIFO logic and sdram_controller.

Parameters:
ADDR_W, 24, SDRAM address width (2 bank + 13 row + 9 col)
DATA_W, 16, data word width (cRGB 1-5-5-5)
MAX_READ_BURST, 8, consecutive read grants allowed while a write is pending
ACCEPT_TIMEOUT, 15, cycles to wait for sd_busy to rise after an enable pulse

Ports:
clock  in  1  system clock (CLOCK_200)
reset  in  1  asynchronous, active-high reset
rd_req  in  1  display read request; held with rd_addr until rd_ack
rd_addr  in  ADDR_W  read address
rd_ack  out  1  one-cycle pulse; rd_data valid in the same cycle
rd_data  out  DATA_W  read word, registered, held until the next rd_ack
wr_req  in  1  pixel write request; held with wr_addr/wr_data until wr_ack
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write word
wr_ack  out  1  one-cycle pulse when the controller finishes the write
sd_addr  out  ADDR_W  to controller wr_addr and rd_addr
sd_wr_data  out  DATA_W  to controller wr_data
sd_wr_enable  out  1  one-cycle write command pulse
sd_rd_enable  out  1  one-cycle read command pulse
sd_rd_data  in  DATA_W  controller rd_data
sd_rd_ready  in  1  controller read-data-valid strobe
sd_busy  in  1  controller busy
timeout_err  out  1  sticky; set on any accept timeout
read_starve_cnt  out  4  consecutive read grants with a write pending (debug)

Behaviour:
- Reset (async, active-high):
  - state=IDLE.
  - All outputs 0: rd_data, sd_addr, sd_wr_data, enables, acks, timeout_err, read_starve_cnt.
- Reset mid-access drops the transaction. No ack is issued, and requesters must re-request.
- States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_ACCEPT, WR_WAIT.
- IDLE arbitration, evaluated only when sd_busy=0:
  - Only rd_req → RD_ISSUE.
  - Only wr_req → WR_ISSUE.
  - Both, with read_starve_cnt<MAX_READ_BURST → RD_ISSUE and read_starve_cnt++.
  - Both, with read_starve_cnt==MAX_READ_BURST → WR_ISSUE.
- read_starve_cnt clears whenever WR_ISSUE is entered, or when IDLE sees wr_req=0.
- sd_busy=1 in IDLE: no grant; state stays IDLE.
- sd_addr/sd_wr_data are registered on grant and held stable until the state returns to IDLE.
- RD_ISSUE: sd_rd_enable=1 for exactly one cycle → RD_WAIT.
- RD_WAIT:
  - On sd_rd_ready=1: rd_data<=sd_rd_data, rd_ack=1 (registered, one cycle), → IDLE.
  - sd_rd_ready arriving the cycle right after the enable is legal.
- WR_ISSUE: sd_wr_enable=1 for one cycle → WR_ACCEPT.
- WR_ACCEPT: wait for sd_busy=1, then → WR_WAIT.
- WR_WAIT: wait for sd_busy=0, then wr_ack=1 for one cycle → IDLE.
- Accept timeout:
  - In WR_ACCEPT or RD_WAIT, a timer counts cycles since the enable pulse.
  - WR_ACCEPT timeout: sd_busy not seen within ACCEPT_TIMEOUT cycles.
  - RD_WAIT timeout: neither sd_busy nor sd_rd_ready seen within ACCEPT_TIMEOUT cycles.
  - On timeout: set timeout_err, → IDLE with no ack; the request is retried by arbitration.
  - RD_WAIT with sd_busy high: the timer freezes; no timeout while the controller is busy.
- Acks:
  - At most one ack per cycle.
  - Never re-grant in the cycle an ack is issued; IDLE is always visited for at least one cycle.
- Requester dropping req before its ack: the issued command still completes and its ack is still pulsed; requesters ignore an unexpected ack.
- Throughput floor: an uncontended read takes 3 cycles plus controller latency.

Test Plan:
- Uncontended read: reset, rd_req with rd_addr=24'h012345; controller returns sd_rd_ready 5 cycles after sd_rd_enable with data 16'hBEEF → sd_addr=24'h012345, one sd_rd_enable pulse, rd_ack one cycle with rd_data=16'hBEEF.
- Uncontended write: wr_req, wr_addr=24'h000100, wr_data=16'h801F; controller busy for 6 cycles → one sd_wr_enable with matching addr/data; wr_ack pulses the cycle after sd_busy falls.
- Starvation cap: rd_req and wr_req held high continuously (MAX_READ_BURST=8) → exactly 8 read grants, then 1 write grant, then read_starve_cnt=0 and the pattern repeats.
- Busy gating: sd_busy held high for 20 cycles with both requests asserted → no enable pulses until sd_busy falls; the first grant after release is the read.
- Timeout: sd_wr_enable issued, sd_busy never rises → timeout_err=1 after 15 cycles, no wr_ack, the write is re-issued from IDLE; timeout_err stays 1 until reset.
- Async reset in RD_WAIT: assert reset between the sd_rd_enable pulse and sd_rd_ready → all outputs 0 immediately, no rd_ack; after release, the held rd_req is re-issued normally.
